trace_buffer: RTL and testbench

Trace-record buffer sitting directly downstream of `trace_unit`. It captures each completed `trace_output` record presented with the `trace_data_ready` strobe, holds records in a first-word-fall-through FIFO, and drains them to a consumer over a valid/ready handshake. When the FIFO is full it drops records and counts them, so the pipeline is never back-pressured.

---
 rtl/trace_buffer.sv | 83 ++++++++
 tb/tb_trace_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// First-word-fall-through buffer for trace records: captures strobed records,
// drains them over valid/ready, and drops-and-counts when full instead of stalling.
module trace_buffer #(
  parameter int  DEPTH        = 16,
  parameter int  AFULL_LEVEL  = 12,
  parameter int  CNT_WIDTH    = 16,
  parameter type trace_output = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_data_ready,
  input  trace_output              trace_data_i,
  input  logic                     flush,
  output logic                     out_valid,
  output trace_output              out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  trace_output     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [OW-1:0]   occ_q;
  logic            push;
  logic            pop;
  logic            drop;

  // Handshake: the head record transfers on any rising edge where out_valid
  // and out_ready are both high; out_valid never depends on out_ready and
  // out_data holds steady while out_valid is high without a transfer.
  assign pop  = out_valid && out_ready;
  assign push = trace_data_ready && !flush && (!full || pop);
  assign drop = trace_data_ready && !flush && full && !pop;

  assign occupancy   = occ_q;
  assign empty       = (occ_q == '0);
  assign full        = (occ_q == OW'(DEPTH));
  assign almost_full = (occ_q >= OW'(AFULL_LEVEL));
  assign out_valid   = !empty;
  assign out_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ_q <= occ_q + OW'(1);
      else if (pop && !push) occ_q <= occ_q - OW'(1);
    end
  end

  // Storage carries no reset; contents are meaningless until occupancy covers them.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= trace_data_i;
  end

  // Drop statistics survive flush and clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped_count != '1) dropped_count <= dropped_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: directed scenarios plus random traffic against a queue model;
// a second instance with a 4-bit drop counter shares the stimulus to cover saturation.
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk;
  logic        rst;
  logic        trace_data_ready;
  logic [31:0] trace_data_i;
  logic        flush;
  logic        out_ready;

  logic        out_valid,   s_out_valid;
  logic [31:0] out_data,    s_out_data;
  logic [4:0]  occupancy,   s_occupancy;
  logic        empty,       s_empty;
  logic        full,        s_full;
  logic        almost_full, s_almost_full;
  logic        overflow,    s_overflow;
  logic [15:0] dropped_count;
  logic [3:0]  s_dropped_count;

  trace_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .trace_data_ready(trace_data_ready),
    .trace_data_i(trace_data_i), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .dropped_count(dropped_count)
  );

  trace_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .trace_data_ready(trace_data_ready),
    .trace_data_i(trace_data_i), .flush(flush), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ready(out_ready), .occupancy(s_occupancy),
    .empty(s_empty), .full(s_full), .almost_full(s_almost_full),
    .overflow(s_overflow), .dropped_count(s_dropped_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q[$];
  int          exp_drops;
  logic        exp_ovf;
  int          errors;
  int          checks;
  int          max_occ;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int n;
    n = exp_q.size();
    check_eq("occupancy",   32'(occupancy),   32'(n));
    check_eq("empty",       32'(empty),       32'(n == 0));
    check_eq("full",        32'(full),        32'(n == DEPTH));
    check_eq("almost_full", 32'(almost_full), 32'(n >= AFULL));
    check_eq("out_valid",   32'(out_valid),   32'(n != 0));
    if (n != 0) check_eq("out_data", out_data, exp_q[0]);
    check_eq("overflow",    32'(overflow),    32'(exp_ovf));
    check_eq("dropped",     32'(dropped_count), 32'((exp_drops > 65535) ? 65535 : exp_drops));
    check_eq("sat_dropped", 32'(s_dropped_count), 32'((exp_drops > 15) ? 15 : exp_drops));
    check_eq("sat_occupancy", 32'(s_occupancy), 32'(n));
    check_eq("sat_overflow",  32'(s_overflow),  32'(exp_ovf));
    if (n != 0) check_eq("sat_out_data", s_out_data, exp_q[0]);
  endtask

  // driver: one clock of stimulus; outputs checked before the edge, model updated after
  task automatic cycle(input logic tv, input logic [31:0] td, input logic rdy, input logic fl);
    logic popped;
    logic was_full;
    trace_data_ready = tv;
    trace_data_i     = td;
    out_ready        = rdy;
    flush            = fl;
    compare_outputs();
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      popped   = rdy && (exp_q.size() > 0);
      was_full = (exp_q.size() == DEPTH);
      if (popped) void'(exp_q.pop_front());
      if (tv) begin
        if (!was_full || popped) exp_q.push_back(td);
        else begin
          exp_drops++;
          exp_ovf = 1'b1;
        end
      end
    end
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
  endtask

  task automatic reset_pulse(input logic tv, input logic rdy);
    rst              = 1'b1;
    trace_data_ready = tv;
    trace_data_i     = $urandom;
    out_ready        = rdy;
    flush            = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    exp_ovf   = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; max_occ = 0;
    exp_drops = 0; exp_ovf = 1'b0;
    rst = 1'b1; trace_data_ready = 1'b0; trace_data_i = '0; flush = 1'b0; out_ready = 1'b0;
    reset_pulse(1'b0, 1'b0);
    reset_pulse(1'b0, 1'b0);

    // single record: visible the cycle after push, popped at the next edge
    cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // fill, overflow by 3, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)     cycle(1'b1, 32'hDEAD + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)    cycle(1'b1, 32'h3000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush with a concurrent push, then a lone record at the head
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h4BAD, 1'b0, 1'b1);
    cycle(1'b1, 32'h4ACE, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // saturation of the narrow counter: 20 more drops
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // reset with push and pop active discards everything
    reset_pulse(1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) == 0));
    end
    // bursts of strobes with a slow consumer to exercise drops
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    check_eq("max_occupancy_bound", 32'(max_occ <= DEPTH), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
